// File: rtl/iccm_arb_pkg.sv
// Shared types and constants for the ICCM port arbiter: read-owner encoding and
// the request bundle that is muxed onto the SRAM macro's port 0.
package iccm_arb_pkg;

    localparam int ICCM_AW = 10;
    localparam int ICCM_DW = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_e;

    typedef struct packed {
        logic                   we;
        logic [ICCM_AW-1:0]     addr;
        logic [ICCM_DW-1:0]     wdata;
        logic [ICCM_DW/8-1:0]   wmask;
    } sram_req_t;

endpackage : iccm_arb_pkg

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive cycles a requester was denied; expired_o forces
// that requester to win the next arbitration.
module arb_starve_ctr #(
    parameter int MAX = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_i,
    input  logic gnt_i,
    input  logic inhibit_i,
    output logic expired_o
);

    localparam logic [3:0] MAX_CNT = 4'(MAX);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!req_i || gnt_i) begin
            cnt_d = 4'd0;
        end else if (!inhibit_i && (cnt_q != MAX_CNT)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == MAX_CNT);

endmodule : arb_starve_ctr

// File: rtl/iccm_port_arbiter.sv
// Shares ICCM SRAM port 0 between the TL-UL adapter (A) and the UART boot loader (B):
// fixed priority to A, starvation guard and program-mode lockout favouring B.
module iccm_port_arbiter
    import iccm_arb_pkg::*;
#(
    parameter int AW         = ICCM_AW,
    parameter int DW         = ICCM_DW,
    parameter int MAX_STARVE = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            prog_mode_i,

    input  logic            a_req_i,
    input  logic            a_we_i,
    input  logic [AW-1:0]   a_addr_i,
    input  logic [DW-1:0]   a_wdata_i,
    input  logic [DW/8-1:0] a_wmask_i,
    output logic            a_gnt_o,
    output logic            a_rvalid_o,
    output logic [DW-1:0]   a_rdata_o,

    input  logic            b_req_i,
    input  logic            b_we_i,
    input  logic [AW-1:0]   b_addr_i,
    input  logic [DW-1:0]   b_wdata_i,
    input  logic [DW/8-1:0] b_wmask_i,
    output logic            b_gnt_o,
    output logic            b_rvalid_o,
    output logic [DW-1:0]   b_rdata_o,

    output logic            sram_csb_o,
    output logic            sram_web_o,
    output logic [DW/8-1:0] sram_wmask_o,
    output logic [AW-1:0]   sram_addr_o,
    output logic [DW-1:0]   sram_wdata_o,
    input  logic [DW-1:0]   sram_rdata_i,

    output logic [15:0]     a_stall_cnt_o
);

    logic      b_expired;
    logic      b_wins;
    sram_req_t req_sel;
    owner_e    owner_q;
    owner_e    owner_d;
    logic [15:0] stall_q;
    logic [15:0] stall_d;

    arb_starve_ctr #(
        .MAX (MAX_STARVE)
    ) u_b_starve (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (b_req_i),
        .gnt_i     (b_gnt_o),
        .inhibit_i (prog_mode_i),
        .expired_o (b_expired)
    );

    // Grants are gated by rst_ni so the macro stays deselected while reset is held.
    always_comb begin
        b_wins  = b_req_i && (prog_mode_i || b_expired || !a_req_i);
        b_gnt_o = rst_ni && b_wins;
        a_gnt_o = rst_ni && a_req_i && !prog_mode_i && !b_wins;
    end

    always_comb begin
        req_sel = '0;
        if (a_gnt_o) begin
            req_sel.we    = a_we_i;
            req_sel.addr  = ICCM_AW'(a_addr_i);
            req_sel.wdata = ICCM_DW'(a_wdata_i);
            req_sel.wmask = (ICCM_DW/8)'(a_wmask_i);
        end else if (b_gnt_o) begin
            req_sel.we    = b_we_i;
            req_sel.addr  = ICCM_AW'(b_addr_i);
            req_sel.wdata = ICCM_DW'(b_wdata_i);
            req_sel.wmask = (ICCM_DW/8)'(b_wmask_i);
        end
    end

    assign sram_csb_o   = !(a_gnt_o || b_gnt_o);
    assign sram_web_o   = !req_sel.we;
    assign sram_addr_o  = AW'(req_sel.addr);
    assign sram_wdata_o = DW'(req_sel.wdata);
    assign sram_wmask_o = (DW/8)'(req_sel.wmask);

    // The owner of each launched read is recorded so the data returned by the
    // macro one cycle later is steered to whoever asked, even across prog-mode flips.
    always_comb begin
        owner_d = OWN_NONE;
        if (a_gnt_o && !a_we_i) begin
            owner_d = OWN_A;
        end else if (b_gnt_o && !b_we_i) begin
            owner_d = OWN_B;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (a_req_i && !a_gnt_o && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q <= OWN_NONE;
            stall_q <= 16'd0;
        end else begin
            owner_q <= owner_d;
            stall_q <= stall_d;
        end
    end

    assign a_rvalid_o    = (owner_q == OWN_A);
    assign b_rvalid_o    = (owner_q == OWN_B);
    assign a_rdata_o     = (owner_q == OWN_A) ? sram_rdata_i : '0;
    assign b_rdata_o     = (owner_q == OWN_B) ? sram_rdata_i : '0;
    assign a_stall_cnt_o = stall_q;

endmodule : iccm_port_arbiter

// File: tb/tb_iccm_port_arbiter.sv
// Randomised plus directed bench for iccm_port_arbiter against a transaction-level
// model of arbitration, read routing and stall counting, with a behavioural SRAM.
`timescale 1ns/1ps
module tb_iccm_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int MAXS = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic prog;
    logic a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic [3:0] a_wmask, b_wmask;
    logic a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic sram_csb, sram_web;
    logic [3:0] sram_wmask;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata, sram_rdata;
    logic [15:0] stall_cnt;

    iccm_port_arbiter #(.AW(AW), .DW(DW), .MAX_STARVE(MAXS)) dut (
        .clk_i(clk), .rst_ni(rst_n), .prog_mode_i(prog),
        .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
        .a_wmask_i(a_wmask), .a_gnt_o(a_gnt), .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata),
        .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
        .b_wmask_i(b_wmask), .b_gnt_o(b_gnt), .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata),
        .sram_csb_o(sram_csb), .sram_web_o(sram_web), .sram_wmask_o(sram_wmask),
        .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata),
        .a_stall_cnt_o(stall_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural macro: registered read, byte-masked write; junk when not reading.
    logic [DW-1:0] mem [1024];
    always @(posedge clk) begin
        if (!sram_csb && !sram_web) begin
            for (int k = 0; k < 4; k++)
                if (sram_wmask[k]) mem[sram_addr][k*8 +: 8] <= sram_wdata[k*8 +: 8];
            sram_rdata <= $urandom;
        end else if (!sram_csb) begin
            sram_rdata <= mem[sram_addr];
        end else begin
            sram_rdata <= $urandom;
        end
    end

    // Reference model state
    logic [DW-1:0] ref_mem [1024];
    int starve, stall, pend;          // pend: 0 none, 1 A, 2 B
    logic [DW-1:0] pend_data;
    logic obs_a_gnt, obs_b_gnt;
    logic [15:0] obs_stall;
    int n_tests = 0, n_fail = 0;
    bit verbose = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [3:0] m);
        logic [DW-1:0] r = old;
        for (int k = 0; k < 4; k++) if (m[k]) r[k*8 +: 8] = nw[k*8 +: 8];
        return r;
    endfunction

    // One cycle: inputs already set just after a negedge; check, advance model, wait.
    task automatic step();
        bit eb, ea;
        logic e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic [3:0] e_wmask;
        #1;
        if (!rst_n) begin
            starve = 0; stall = 0; pend = 0;
        end
        eb = rst_n && b_req && (prog || starve >= MAXS || !a_req);
        ea = rst_n && a_req && !prog && !eb;
        e_we = ea ? a_we : eb ? b_we : 1'b0;
        e_addr = ea ? a_addr : eb ? b_addr : '0;
        e_wdata = ea ? a_wdata : eb ? b_wdata : '0;
        e_wmask = ea ? a_wmask : eb ? b_wmask : '0;
        chk("a_gnt", a_gnt, ea);
        chk("b_gnt", b_gnt, eb);
        chk("csb", sram_csb, !(ea || eb));
        chk("web", sram_web, !e_we);
        chk("addr", sram_addr, e_addr);
        chk("wdata", sram_wdata, e_wdata);
        chk("wmask", sram_wmask, e_wmask);
        chk("a_rvalid", a_rvalid, pend == 1);
        chk("b_rvalid", b_rvalid, pend == 2);
        chk("a_rdata", a_rdata, (pend == 1) ? pend_data : '0);
        chk("b_rdata", b_rdata, (pend == 2) ? pend_data : '0);
        chk("stall_cnt", stall_cnt, 16'(stall));
        obs_a_gnt = a_gnt; obs_b_gnt = b_gnt; obs_stall = stall_cnt;
        if (verbose && (ea || eb))
            $display("[TB] t=%0t grant=%s we=%0d addr=%0h wdata=%h stall=%0d",
                     $time, ea ? "A" : "B", e_we, e_addr, e_wdata, stall);
        if (rst_n) begin
            pend = 0;
            if ((ea || eb) && !e_we) begin
                pend = ea ? 1 : 2;
                pend_data = ref_mem[e_addr];
            end
            if ((ea || eb) && e_we) ref_mem[e_addr] = merge(ref_mem[e_addr], e_wdata, e_wmask);
            if (b_req && !eb && !prog) starve = (starve < MAXS) ? starve + 1 : MAXS;
            else if (eb || !b_req) starve = 0;
            if (a_req && !ea && stall < 65535) stall++;
        end
        @(negedge clk);
    endtask

    task automatic new_a();
        a_req = ($urandom_range(0, 3) != 0);
        a_we = $urandom_range(0, 1);
        a_addr = AW'($urandom_range(0, 31));
        a_wdata = $urandom;
        a_wmask = 4'($urandom);
    endtask

    task automatic new_b();
        b_req = ($urandom_range(0, 2) != 0);
        b_we = $urandom_range(0, 1);
        b_addr = AW'($urandom_range(0, 31));
        b_wdata = $urandom;
        b_wmask = 4'($urandom);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        sram_rdata = '0;
        starve = 0; stall = 0; pend = 0; pend_data = '0;
        rst_n = 1'b0; prog = 1'b0;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0; a_wmask = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0; b_wmask = '0;
        @(negedge clk);
        step(); step();
        rst_n = 1'b1;
        step();
        verbose = 1'b1;

        // A write then read-back of 0xDEADBEEF at word 4
        a_req = 1; a_we = 1; a_addr = 10'h004; a_wdata = 32'hDEADBEEF; a_wmask = 4'hF;
        step();
        a_we = 0;
        step();
        a_req = 0;
        #1;
        chk("rd_back_valid", a_rvalid, 1'b1);
        chk("rd_back_data", a_rdata, 32'hDEADBEEF);
        chk("rd_back_b_quiet", b_rvalid, 1'b0);
        step();

        // Both requesting continuously: starvation guard yields A,A,A,A,B
        a_req = 1; a_we = 0; a_addr = 10'h004;
        b_req = 1; b_we = 1; b_addr = 10'h009; b_wdata = 32'h1234_5678; b_wmask = 4'hF;
        repeat (15) step();
        a_req = 0; b_req = 0;
        step();

        // Program mode: B streams eight writes while A is locked out
        rst_n = 0;
        step();
        rst_n = 1;
        prog = 1; a_req = 1; a_we = 0; a_addr = 10'h004;
        for (int i = 0; i < 8; i++) begin
            b_req = 1; b_we = 1; b_addr = AW'(i); b_wdata = $urandom; b_wmask = 4'hF;
            step();
            chk("prog_b_gnt", obs_b_gnt, 1'b1);
        end
        b_req = 0; prog = 0;
        step();
        chk("prog_release_a_gnt", obs_a_gnt, 1'b1);
        chk("prog_stall8", obs_stall, 16'd8);

        // Read launched the cycle before prog mode rises still returns to A
        a_req = 1; a_we = 0; a_addr = 10'h003;
        step();
        prog = 1; b_req = 1; b_we = 1; b_addr = 10'h014; b_wdata = 32'hCAFE_F00D; b_wmask = 4'h3;
        step();
        prog = 0; a_req = 0; b_req = 0;
        step();

        // Reset pulse right after an A read grant discards the pending return
        a_req = 1; a_we = 0; a_addr = 10'h004;
        step();
        rst_n = 0; a_req = 0;
        step();
        step();
        rst_n = 1;
        step();
        verbose = 1'b0;

        // Randomised traffic; requesters hold payload until granted
        new_a(); new_b();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) prog = ~prog;
            rst_n = ($urandom_range(0, 499) != 0);
            step();
            if (obs_a_gnt || !a_req) new_a();
            if (obs_b_gnt || !b_req) new_b();
        end
        rst_n = 1; prog = 0; a_req = 0; b_req = 0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_iccm_port_arbiter

// File: doc/iccm_port_arbiter.md
Name: iccm_port_arbiter

Overview:
- Shares the single read/write port of the 32x1024 ICCM SRAM macro between two requesters: port A, the TL-UL instruction-memory adapter (core fetch and debug/LSU accesses), and port B, the UART boot-loader write path driven by the ICCM programming controller.
- Sits between both requesters and the macro's port 0. The macro's port 1 stays tied off.
- Provides fixed-priority arbitration with a starvation guard, a program-mode lockout, and read-response routing.

Parameters:
- AW, 10, SRAM word-address width
- DW, 32, data width; the write mask is DW/8 bits wide
- MAX_STARVE, 4, consecutive denied cycles of B after which B wins the next arbitration (range 1..15)

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- prog_mode_i  in  1  1 = loader owns the SRAM; A is locked out
- a_req_i  in  1  A access request
- a_we_i  in  1  A write (1) / read (0)
- a_addr_i  in  AW  A word address
- a_wdata_i  in  DW  A write data
- a_wmask_i  in  DW/8  A byte-enable mask
- a_gnt_o  out  1  A request accepted this cycle
- a_rvalid_o  out  1  A read data valid
- a_rdata_o  out  DW  A read data
- b_req_i, b_we_i, b_addr_i, b_wdata_i, b_wmask_i  in  1/1/AW/DW/DW/8  loader request, same meaning as for A
- b_gnt_o  out  1  B request accepted this cycle
- b_rvalid_o  out  1  B read data valid
- b_rdata_o  out  DW  B read data
- sram_csb_o  out  1  active-low chip select
- sram_web_o  out  1  active-low write enable
- sram_wmask_o  out  DW/8  write mask
- sram_addr_o  out  AW  SRAM address
- sram_wdata_o  out  DW  SRAM write data
- sram_rdata_i  in  DW  SRAM read data, valid one cycle after a read is launched
- a_stall_cnt_o  out  16  saturating count of cycles in which a_req_i was high and a_gnt_o low

Behaviour:
- Reset values: a_gnt_o/b_gnt_o 0, a_rvalid_o/b_rvalid_o 0, sram_csb_o 1, sram_web_o 1, sram_addr_o/wdata_o/wmask_o 0, starvation counter 0, a_stall_cnt_o 0, read-owner register NONE.
- Grants are combinational and issued in the same cycle as the request. At most one grant per cycle.
- Requesters hold request and payload stable until granted.
- Arbitration priority:
  - prog_mode_i = 1: only B can be granted; a_gnt_o = 0.
  - prog_mode_i = 0, starvation counter == MAX_STARVE: B wins.
  - Otherwise: A wins.
- Starvation counter:
  - Increments when b_req_i is high, b_gnt_o is low and prog_mode_i is 0.
  - Clears when B is granted or b_req_i drops.
  - Never exceeds MAX_STARVE.
- SRAM drive:
  - Granted cycle: sram_csb_o = 0, sram_web_o = ~we, and addr/wdata/wmask come from the winner.
  - No grant: csb = 1, web = 1, addr/wdata/wmask = 0.
- Read return:
  - A granted read sets the owner register (A or B).
  - In the next cycle the owner's rvalid_o is 1 and its rdata_o = sram_rdata_i. The other rdata_o is 0.
  - Writes produce no rvalid.
  - Back-to-back reads pipeline at one per cycle; the owner register updates every cycle.
- prog_mode_i change:
  - Takes effect for the arbitration of the same cycle.
  - A read already launched still returns to its original owner the next cycle.
- a_stall_cnt_o: increments on each stalled A cycle, including cycles lost to prog-mode lockout. Saturates at 16'hFFFF. Clears only on reset.
- Reset asserted mid-operation: all state clears immediately. A read return pending at that point is discarded (no rvalid after reset).

Decomposition:
- Shared package iccm_arb_pkg holds:
  - owner_e enum {OWN_NONE, OWN_A, OWN_B}
  - sram_req_t struct {we, addr, wdata, wmask}
  - ICCM_AW = 10 constant
- One natural sub-module, arb_starve_ctr: the saturating starvation counter, with inputs req, gnt, inhibit and output expired.
- The priority mux, owner register and stall counter stay in the top-level module.

Test Plan:
- Both requesters idle after reset -> csb = 1, web = 1, rvalid = 0, a_stall_cnt_o = 0.
- A writes 32'hDEADBEEF to addr 10'h004 with mask 4'hF, then reads 10'h004 -> a_gnt_o = 1 on both request cycles; a_rvalid_o = 1 exactly one cycle after the read grant with a_rdata_o = 32'hDEADBEEF; b_rvalid_o stays 0.
- a_req_i and b_req_i held high continuously with MAX_STARVE = 4 -> grant sequence A,A,A,A,B repeating; a_stall_cnt_o increments once per B grant.
- prog_mode_i = 1 while A requests and B streams writes to addrs 0..7 -> b_gnt_o = 1 every cycle, a_gnt_o = 0, a_stall_cnt_o = 8; after prog_mode_i drops, A is granted in the same cycle.
- A read granted in the cycle before prog_mode_i rises -> a_rvalid_o = 1 in the next cycle with the correct data, while B receives that cycle's grant.
- rst_ni pulsed low in the cycle after an A read grant -> a_rvalid_o = 0, csb = 1 and all counters 0 while reset is low and on release.
